// File: rtl/pwm_demod.sv
// pwm_demod: recovers one CNT_W-bit sample per frame from a frame-aligned PWM
// line. The frame counter locks to the first rising edge. It then counts high
// cycles per frame. A rising edge away from frame index 0 realigns the counter
// and drops the partial frame.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HUNT | waiting for the first rising edge; counters held at zero
// ST_LOCK | frame counter free-running; one sample per frame is reported
module pwm_demod #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_256M,
  input  logic             rst,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] data_o,
  output logic             data_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] FCNT_ZERO = '0;
  localparam logic [CNT_W-1:0] FCNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FCNT_LAST = '1;
  localparam logic [CNT_W:0]   HCNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  // Largest value that fits in data_o; a full-high frame (2^CNT_W) clamps here.
  localparam logic [CNT_W:0]   HCNT_SAT  = {1'b0, {CNT_W{1'b1}}};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [CNT_W:0]         hcnt_q, hcnt_d;
  logic [CNT_W:0]         hsum;
  logic [CNT_W-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign hsum = hcnt_q + {{CNT_W{1'b0}}, s};

  // Synchronize the asynchronous PWM line and keep one cycle of history for edge detection.
  always_ff @(posedge clk_256M) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      s_d_q  <= s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_256M) begin
    if (rst) begin
      state_q <= ST_HUNT;
      fcnt_q  <= '0;
      hcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      hcnt_q  <= hcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state: lock on the first edge. In lock, count frames and report high time.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        fcnt_d = '0;
        hcnt_d = '0;
        if (rise) begin
          // The edge sample itself is frame index 0 and counts as one high cycle.
          fcnt_d  = FCNT_ONE;
          hcnt_d  = HCNT_ONE;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (rise && (fcnt_q != FCNT_ZERO)) begin
          // A misplaced edge wins over a frame end; the partial frame is dropped.
          err_d  = 1'b1;
          fcnt_d = FCNT_ONE;
          hcnt_d = HCNT_ONE;
        end else begin
          fcnt_d = fcnt_q + FCNT_ONE;
          if (fcnt_q == FCNT_ZERO) begin
            hcnt_d = {{CNT_W{1'b0}}, s};
          end else begin
            hcnt_d = hsum;
          end
          if (fcnt_q == FCNT_LAST) begin
            valid_d = 1'b1;
            data_d  = (hsum > HCNT_SAT) ? HCNT_SAT[CNT_W-1:0] : hsum[CNT_W-1:0];
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  assign data_o     = data_q;
  assign data_valid = valid_q;
  assign sync_err   = err_q;
  assign locked     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod. Each scenario resets the DUT and plays a bit stream.
// It records every data_valid/sync_err event. A frame-window reference model
// derives the expected events from the same stream.
module tb_pwm_demod;
  localparam int CNT_W = 8;
  localparam int S     = 2;
  localparam int FRAME = 1 << CNT_W;
  localparam int MAXV  = FRAME - 1;

  logic             clk_256M = 1'b0;
  logic             rst      = 1'b0;
  logic             pwm_i    = 1'b0;
  logic [CNT_W-1:0] data_o;
  logic             data_valid;
  logic             locked;
  logic             sync_err;

  int total = 0;
  int bad   = 0;

  bit bits_q[$];
  int got_vt[$], got_vv[$], got_et[$];
  int exp_vt[$], exp_vv[$], exp_et[$];
  int exp_lock;
  int got_locked_end, got_data_end;

  pwm_demod #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .clk_256M   (clk_256M),
    .rst        (rst),
    .pwm_i      (pwm_i),
    .data_o     (data_o),
    .data_valid (data_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #2 clk_256M = ~clk_256M;

  function automatic void add_zeros(input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(1'b0);
  endfunction

  function automatic void add_partial(input int v, input int len);
    for (int i = 0; i < len; i++) bits_q.push_back(i < v);
  endfunction

  function automatic void add_frame(input int v);
    add_partial(v, FRAME);
  endfunction

  // Reference: s[t] is the synchronized line after reset edge + t cycles.
  // Frames are 2^CNT_W-sample windows starting at the lock edge. A rising edge
  // anywhere but window start restarts the window. Each completed window
  // reports its clamped population one cycle later.
  task automatic model(input int L);
    bit s[];
    int start, idx, sum, k;
    bit rise;
    s = new[L + 1];
    exp_vt.delete(); exp_vv.delete(); exp_et.delete();
    exp_lock = -1;
    start = -1;
    for (int t = 0; t <= L; t++) begin
      k = t - S;
      s[t] = (k >= 0 && k < bits_q.size()) ? bits_q[k] : 1'b0;
    end
    for (int t = 1; t < L; t++) begin
      rise = s[t] && !s[t-1];
      if (start < 0) begin
        if (rise) begin
          start = t;
          exp_lock = t + 1;
        end
      end else begin
        idx = (t - start) % FRAME;
        if (rise && idx != 0) begin
          exp_et.push_back(t + 1);
          start = t;
        end else if (idx == FRAME - 1) begin
          sum = 0;
          for (int j = t - FRAME + 1; j <= t; j++) sum += int'(s[j]);
          exp_vt.push_back(t + 1);
          exp_vv.push_back(sum > MAXV ? MAXV : sum);
        end
      end
    end
  endtask

  task automatic run_stream(input string name);
    int n, L, exp_d, exp_l;
    n = bits_q.size();
    L = n + S + 1;
    got_vt.delete(); got_vv.delete(); got_et.delete();
    @(negedge clk_256M);
    rst = 1'b1;
    pwm_i = 1'b0;
    @(negedge clk_256M);
    rst = 1'b0;
    total++;
    if (data_o !== '0) begin bad++; $display("FAIL %s rst_data got=%0d exp=0", name, data_o); end
    total++;
    if (data_valid !== 1'b0) begin bad++; $display("FAIL %s rst_valid got=%b exp=0", name, data_valid); end
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL %s rst_locked got=%b exp=0", name, locked); end
    total++;
    if (sync_err !== 1'b0) begin bad++; $display("FAIL %s rst_err got=%b exp=0", name, sync_err); end
    for (int i = 0; i < L; i++) begin
      pwm_i = (i < n) ? bits_q[i] : 1'b0;
      @(negedge clk_256M);
      if (data_valid === 1'b1) begin
        got_vt.push_back(i + 1);
        got_vv.push_back(int'(data_o));
      end
      if (sync_err === 1'b1) got_et.push_back(i + 1);
    end
    got_locked_end = int'(locked);
    got_data_end   = int'(data_o);
    model(L);
    total++;
    if (got_vt.size() != exp_vt.size()) begin
      bad++; $display("FAIL %s valid_count got=%0d exp=%0d", name, got_vt.size(), exp_vt.size());
    end
    for (int i = 0; i < exp_vt.size() && i < got_vt.size(); i++) begin
      total++;
      if (got_vt[i] != exp_vt[i] || got_vv[i] != exp_vv[i]) begin
        bad++;
        $display("FAIL %s sample%0d got=(t%0d,%0d) exp=(t%0d,%0d)", name, i, got_vt[i], got_vv[i], exp_vt[i], exp_vv[i]);
      end
    end
    total++;
    if (got_et.size() != exp_et.size()) begin
      bad++; $display("FAIL %s err_count got=%0d exp=%0d", name, got_et.size(), exp_et.size());
    end
    for (int i = 0; i < exp_et.size() && i < got_et.size(); i++) begin
      total++;
      if (got_et[i] != exp_et[i]) begin
        bad++; $display("FAIL %s err%0d_time got=%0d exp=%0d", name, i, got_et[i], exp_et[i]);
      end
    end
    exp_d = (exp_vv.size() > 0) ? exp_vv[exp_vv.size()-1] : 0;
    exp_l = (exp_lock >= 0 && exp_lock <= L) ? 1 : 0;
    total++;
    if (got_data_end != exp_d) begin bad++; $display("FAIL %s held_data got=%0d exp=%0d", name, got_data_end, exp_d); end
    total++;
    if (got_locked_end != exp_l) begin bad++; $display("FAIL %s end_locked got=%0d exp=%0d", name, got_locked_end, exp_l); end
  endtask

  task automatic test_reset_idle();
    bits_q.delete();
    add_zeros(1000);
    run_stream("idle");
    total++;
    if (got_locked_end != 0 || got_vt.size() != 0) begin
      bad++; $display("FAIL idle_quiet got=locked%0d,valids%0d exp=locked0,valids0", got_locked_end, got_vt.size());
    end
  endtask

  task automatic test_value128();
    bits_q.delete();
    add_zeros($urandom_range(0, 40));
    repeat (4) add_frame(128);
    run_stream("v128");
    total++;
    if (got_vv.size() != 4 || got_et.size() != 0) begin
      bad++; $display("FAIL v128_shape got=valids%0d,errs%0d exp=valids4,errs0", got_vv.size(), got_et.size());
    end
    foreach (got_vv[i]) begin
      total++;
      if (got_vv[i] != 128) begin bad++; $display("FAIL v128_value%0d got=%0d exp=128", i, got_vv[i]); end
    end
  endtask

  task automatic test_sequence();
    int want[5] = '{128, 1, 255, 0, 200};
    bits_q.delete();
    add_zeros($urandom_range(0, 40));
    foreach (want[i]) add_frame(want[i]);
    run_stream("seq");
    total++;
    if (got_vv.size() != 5) begin bad++; $display("FAIL seq_count got=%0d exp=5", got_vv.size()); end
    for (int i = 0; i < 5 && i < got_vv.size(); i++) begin
      total++;
      if (got_vv[i] != want[i]) begin bad++; $display("FAIL seq_value%0d got=%0d exp=%0d", i, got_vv[i], want[i]); end
    end
  endtask

  task automatic test_stuck_high();
    bits_q.delete();
    add_zeros(3);
    add_frame(64);
    add_frame(256);
    add_frame(256);
    add_frame(10);
    run_stream("stuck");
    total++;
    if (got_vv.size() != 4 || (got_vv.size() == 4 && (got_vv[1] != 255 || got_vv[2] != 255))) begin
      bad++; $display("FAIL stuck_sat got=%0d valids exp=4 with 255,255 in middle", got_vv.size());
    end
  endtask

  task automatic test_misalign(input int cut);
    bits_q.delete();
    add_zeros(5);
    add_frame(50);
    add_frame(50);
    add_partial(50, cut);
    repeat (3) add_frame(50);
    run_stream($sformatf("misalign%0d", cut));
    total++;
    if (got_et.size() != 1 || got_vv.size() != 5) begin
      bad++; $display("FAIL misalign%0d_shape got=errs%0d,valids%0d exp=errs1,valids5", cut, got_et.size(), got_vv.size());
    end
  endtask

  task automatic test_mid_reset();
    bits_q.delete();
    add_zeros(9);
    add_frame(80);
    add_partial(80, 128);
    run_stream("pre_reset");
    total++;
    if (got_locked_end != 1) begin bad++; $display("FAIL pre_reset_locked got=%0d exp=1", got_locked_end); end
    bits_q.delete();
    add_zeros(7);
    repeat (3) add_frame(30);
    run_stream("post_reset");
  endtask

  task automatic test_random();
    int nf, cut_at;
    for (int it = 0; it < 4; it++) begin
      bits_q.delete();
      add_zeros($urandom_range(0, 300));
      nf = $urandom_range(3, 6);
      cut_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, nf - 1) : -1;
      for (int f = 0; f < nf; f++) begin
        if (f == cut_at) add_partial($urandom_range(0, 256), $urandom_range(1, FRAME - 1));
        add_frame($urandom_range(0, 256));
      end
      run_stream($sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset_idle();
    test_value128();
    test_sequence();
    test_stuck_high();
    test_misalign(100);
    test_misalign(255);
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
